// File: rtl/pulse_cfg_ctrl.sv
// Shadowed DELAY/WIDTH configuration sequencer: commits are applied atomically once the
// pulse block queue drains or is flushed. Optional drain timeout: define PULSE_CFG_TIMEOUT_EN.
module pulse_cfg_ctrl #(
   parameter int TS_W          = 48,
   parameter int QUEUE_W       = 11,
   parameter int DRAIN_TIMEOUT = 4096
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic               reg_wr_i,
   input  logic [2:0]         reg_addr_i,
   input  logic [31:0]        reg_data_i,
   input  logic [QUEUE_W-1:0] queue_i,
   input  logic               out_i,
   output logic [TS_W-1:0]    DELAY_o,
   output logic [TS_W-1:0]    WIDTH_o,
   output logic               FORCE_RST_o,
   output logic               busy_o,
   output logic               cfg_err_o,
   output logic               tmo_err_o,
   output logic [15:0]        commit_cnt_o
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_DRAIN  = 3'd1,
      ST_FLUSH  = 3'd2,
      ST_SETTLE = 3'd3,
      ST_APPLY  = 3'd4
   } state_t;

   localparam logic [2:0] ADDR_DELAY_L = 3'd0;
   localparam logic [2:0] ADDR_DELAY_H = 3'd1;
   localparam logic [2:0] ADDR_WIDTH_L = 3'd2;
   localparam logic [2:0] ADDR_WIDTH_H = 3'd3;
   localparam logic [2:0] ADDR_CTRL    = 3'd4;

   state_t            state_q, state_d;
   logic [TS_W-1:0]   sh_delay_q, sh_delay_d;
   logic [TS_W-1:0]   sh_width_q, sh_width_d;
   logic [TS_W-1:0]   cp_delay_q, cp_delay_d;
   logic [TS_W-1:0]   cp_width_q, cp_width_d;
   logic              commit_pend_q, commit_pend_d;
   logic              force_pend_q, force_pend_d;
   logic              commit_path_q, commit_path_d;
   logic              settle_q, settle_d;
   logic [TS_W-1:0]   delay_q, delay_d;
   logic [TS_W-1:0]   width_q, width_d;
   logic              force_rst_q, force_rst_d;
   logic              busy_q, busy_d;
   logic              cfg_err_q, cfg_err_d;
   logic [15:0]       cnt_q, cnt_d;

   logic              wr_ctrl_s, commit_wr_s, force_wr_s, err_clr_s;
   logic              drained_s;
   logic              take_force_s, take_commit_s, reject_s;

`ifdef PULSE_CFG_TIMEOUT_EN
   localparam int TMO_W = (DRAIN_TIMEOUT > 2) ? $clog2(DRAIN_TIMEOUT) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(DRAIN_TIMEOUT - 1);
   localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

   logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
   logic              tmo_err_q, tmo_err_d;
   logic              tmo_hit_s;
`endif

   assign wr_ctrl_s   = reg_wr_i && (reg_addr_i == ADDR_CTRL);
   assign commit_wr_s = wr_ctrl_s && reg_data_i[0];
   assign force_wr_s  = wr_ctrl_s && reg_data_i[1];
   assign err_clr_s   = wr_ctrl_s && (reg_data_i[1:0] == 2'b00);
   assign drained_s   = (queue_i == '0) && !out_i;

   // FSM state register
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic; FORCE outranks a pending COMMIT in IDLE
   always_comb begin
      state_d       = state_q;
      take_force_s  = 1'b0;
      take_commit_s = 1'b0;
      reject_s      = 1'b0;
`ifdef PULSE_CFG_TIMEOUT_EN
      tmo_hit_s     = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (force_pend_q) begin
               take_force_s = 1'b1;
               state_d      = ST_FLUSH;
            end else if (commit_pend_q) begin
               if (sh_width_q == '0) begin
                  reject_s = 1'b1;
                  state_d  = ST_IDLE;
               end else begin
                  take_commit_s = 1'b1;
                  state_d       = ST_DRAIN;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_DRAIN: begin
`ifdef PULSE_CFG_TIMEOUT_EN
            // drain wins a tie with the timeout
            if (drained_s) begin
               state_d = ST_APPLY;
            end else if (tmo_cnt_q == TMO_LAST) begin
               tmo_hit_s = 1'b1;
               state_d   = ST_FLUSH;
            end else begin
               state_d = ST_DRAIN;
            end
`else
            if (drained_s) begin
               state_d = ST_APPLY;
            end else begin
               state_d = ST_DRAIN;
            end
`endif
         end
         ST_FLUSH: begin
            state_d = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (settle_q) begin
               state_d = commit_path_q ? ST_APPLY : ST_IDLE;
            end else begin
               state_d = ST_SETTLE;
            end
         end
         ST_APPLY: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Shadow registers, pending requests and commit snapshot
   always_comb begin
      sh_delay_d = sh_delay_q;
      sh_width_d = sh_width_q;
      if (reg_wr_i) begin
         case (reg_addr_i)
            ADDR_DELAY_L: sh_delay_d[31:0]      = reg_data_i;
            ADDR_DELAY_H: sh_delay_d[TS_W-1:32] = reg_data_i[TS_W-33:0];
            ADDR_WIDTH_L: sh_width_d[31:0]      = reg_data_i;
            ADDR_WIDTH_H: sh_width_d[TS_W-1:32] = reg_data_i[TS_W-33:0];
            default: begin
               sh_delay_d = sh_delay_q;
               sh_width_d = sh_width_q;
            end
         endcase
      end else begin
         sh_delay_d = sh_delay_q;
         sh_width_d = sh_width_q;
      end

      // a request written on the edge that consumes the pending one merges into it
      if (take_commit_s || reject_s) begin
         commit_pend_d = 1'b0;
      end else begin
         commit_pend_d = commit_pend_q | commit_wr_s;
      end
      if (take_force_s) begin
         force_pend_d = 1'b0;
      end else begin
         force_pend_d = force_pend_q | force_wr_s;
      end

      if (take_commit_s) begin
         cp_delay_d    = sh_delay_q;
         cp_width_d    = sh_width_q;
         commit_path_d = 1'b1;
      end else if (take_force_s) begin
         cp_delay_d    = cp_delay_q;
         cp_width_d    = cp_width_q;
         commit_path_d = 1'b0;
      end else begin
         cp_delay_d    = cp_delay_q;
         cp_width_d    = cp_width_q;
         commit_path_d = commit_path_q;
      end

      settle_d = (state_q == ST_SETTLE);
   end

   // FSM output logic: next values of the registered outputs
   always_comb begin
      force_rst_d = (state_d == ST_FLUSH);
      busy_d      = (state_d != ST_IDLE) | commit_pend_d | force_pend_d;
      cfg_err_d   = reject_s | (cfg_err_q & ~err_clr_s);
      if (state_q == ST_APPLY) begin
         delay_d = cp_delay_q;
         width_d = cp_width_q;
         cnt_d   = cnt_q + 16'd1;
      end else begin
         delay_d = delay_q;
         width_d = width_q;
         cnt_d   = cnt_q;
      end
   end

   // Datapath and output registers
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sh_delay_q    <= '0;
         sh_width_q    <= '0;
         cp_delay_q    <= '0;
         cp_width_q    <= '0;
         commit_pend_q <= 1'b0;
         force_pend_q  <= 1'b0;
         commit_path_q <= 1'b0;
         settle_q      <= 1'b0;
         delay_q       <= '0;
         width_q       <= '0;
         force_rst_q   <= 1'b0;
         busy_q        <= 1'b0;
         cfg_err_q     <= 1'b0;
         cnt_q         <= 16'd0;
      end else begin
         sh_delay_q    <= sh_delay_d;
         sh_width_q    <= sh_width_d;
         cp_delay_q    <= cp_delay_d;
         cp_width_q    <= cp_width_d;
         commit_pend_q <= commit_pend_d;
         force_pend_q  <= force_pend_d;
         commit_path_q <= commit_path_d;
         settle_q      <= settle_d;
         delay_q       <= delay_d;
         width_q       <= width_d;
         force_rst_q   <= force_rst_d;
         busy_q        <= busy_d;
         cfg_err_q     <= cfg_err_d;
         cnt_q         <= cnt_d;
      end
   end

`ifdef PULSE_CFG_TIMEOUT_EN
   // Timeout counter is zero on DRAIN entry and advances every DRAIN cycle
   always_comb begin
      if (state_q == ST_DRAIN) begin
         tmo_cnt_d = tmo_cnt_q + TMO_ONE;
      end else begin
         tmo_cnt_d = '0;
      end
      tmo_err_d = tmo_hit_s | (tmo_err_q & ~err_clr_s);
   end

   // Timeout counter and sticky timeout error registers
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         tmo_cnt_q <= '0;
         tmo_err_q <= 1'b0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
         tmo_err_q <= tmo_err_d;
      end
   end

   assign tmo_err_o = tmo_err_q;
`else
   assign tmo_err_o = 1'b0;
`endif

   assign DELAY_o      = delay_q;
   assign WIDTH_o      = width_q;
   assign FORCE_RST_o  = force_rst_q;
   assign busy_o       = busy_q;
   assign cfg_err_o    = cfg_err_q;
   assign commit_cnt_o = cnt_q;

endmodule

// File: tb/tb_pulse_cfg_ctrl.sv
// Self-checking bench for pulse_cfg_ctrl: directed sequences, a vector table and
// randomized commit transactions against a transaction-level model.
module tb_pulse_cfg_ctrl;
   localparam int DT = 64;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        reg_wr = 1'b0;
   logic [2:0]  reg_addr = 3'd0;
   logic [31:0] reg_data = 32'd0;
   logic [10:0] queue = 11'd0;
   logic        out_lvl = 1'b0;
   logic [47:0] delay_o, width_o;
   logic        force_rst_o, busy_o, cfg_err_o, tmo_err_o;
   logic [15:0] cnt_o;

   int n_pass = 0;
   int n_total = 0;
   int fr_pulses = 0;
   int p0;

   pulse_cfg_ctrl #(.TS_W(48), .QUEUE_W(11), .DRAIN_TIMEOUT(DT)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .reg_wr_i(reg_wr), .reg_addr_i(reg_addr),
      .reg_data_i(reg_data), .queue_i(queue), .out_i(out_lvl),
      .DELAY_o(delay_o), .WIDTH_o(width_o), .FORCE_RST_o(force_rst_o),
      .busy_o(busy_o), .cfg_err_o(cfg_err_o), .tmo_err_o(tmo_err_o),
      .commit_cnt_o(cnt_o));

   always #5 clk = ~clk;

   always @(negedge clk) if (force_rst_o) fr_pulses++;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      reg_addr = a; reg_data = d; reg_wr = 1'b1;
      @(negedge clk);
      reg_wr = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; queue = 11'd0; out_lvl = 1'b0;
      cyc(2);
      rst_n = 1'b1;
      cyc(1);
   endtask

   typedef struct {
      logic [2:0]  addr;
      logic [31:0] data;
      logic [47:0] e_delay;
      logic [47:0] e_width;
      logic [15:0] e_cnt;
      logic        e_cfg;
      int          e_pulses;
   } vec_t;

   vec_t tbl[12];

   // transaction-level model state for the random phase
   logic [47:0] m_sh_d, m_sh_w, m_delay, m_width;
   logic [15:0] m_cnt;
   logic        m_cfg;

   initial begin
      tbl[0]  = '{3'd0, 32'd100,     48'd0,            48'd0,            16'd0, 1'b0, 0};
      tbl[1]  = '{3'd2, 32'd20,      48'd0,            48'd0,            16'd0, 1'b0, 0};
      tbl[2]  = '{3'd4, 32'd1,       48'd100,          48'd20,           16'd1, 1'b0, 0};
      tbl[3]  = '{3'd1, 32'd1,       48'd100,          48'd20,           16'd1, 1'b0, 0};
      tbl[4]  = '{3'd2, 32'd0,       48'd100,          48'd20,           16'd1, 1'b0, 0};
      tbl[5]  = '{3'd4, 32'd1,       48'd100,          48'd20,           16'd1, 1'b1, 0};
      tbl[6]  = '{3'd4, 32'd0,       48'd100,          48'd20,           16'd1, 1'b0, 0};
      tbl[7]  = '{3'd3, 32'hABCD,    48'd100,          48'd20,           16'd1, 1'b0, 0};
      tbl[8]  = '{3'd4, 32'd1,       48'h1_0000_0064,  48'hABCD_0000_0000, 16'd2, 1'b0, 0};
      tbl[9]  = '{3'd4, 32'd2,       48'h1_0000_0064,  48'hABCD_0000_0000, 16'd2, 1'b0, 1};
      tbl[10] = '{3'd2, 32'd5,       48'h1_0000_0064,  48'hABCD_0000_0000, 16'd2, 1'b0, 0};
      tbl[11] = '{3'd4, 32'd3,       48'h1_0000_0064,  48'hABCD_0000_0005, 16'd3, 1'b0, 1};

      // reset state
      cyc(3);
      rst_n = 1'b1;
      cyc(1);
      chk("rst_delay", delay_o, 0);
      chk("rst_width", width_o, 0);
      chk("rst_force", force_rst_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_cfg", cfg_err_o, 0);
      chk("rst_tmo", tmo_err_o, 0);
      chk("rst_cnt", cnt_o, 0);

      // drained commit: outputs change exactly after the third edge
      do_reset();
      p0 = fr_pulses;
      wr(3'd0, 32'd100);
      wr(3'd2, 32'd20);
      wr(3'd4, 32'd1);
      chk("drain_busy_e0", busy_o, 1);
      cyc(2);
      chk("drain_delay_e2", delay_o, 0);
      cyc(1);
      chk("drain_delay_e3", delay_o, 100);
      chk("drain_width_e3", width_o, 20);
      chk("drain_cnt_e3", cnt_o, 1);
      chk("drain_busy_e3", busy_o, 0);
      chk("drain_no_pulse", fr_pulses - p0, 0);

      // busy queue drains after 50 cycles
      do_reset();
      wr(3'd2, 32'd20);
      queue = 11'd5;
      wr(3'd0, 32'd200);
      wr(3'd4, 32'd1);
      cyc(50);
      chk("bq_delay_held", delay_o, 0);
      chk("bq_busy_held", busy_o, 1);
      queue = 11'd0;
      cyc(1);
      chk("bq_delay_d1", delay_o, 0);
      cyc(1);
      chk("bq_delay_d2", delay_o, 200);
      chk("bq_tmo", tmo_err_o, 0);
      chk("bq_busy", busy_o, 0);

      // stuck queue: timeout flush when compiled in, indefinite wait otherwise
      do_reset();
      wr(3'd2, 32'd20);
      wr(3'd0, 32'd300);
      queue = 11'd3;
      wr(3'd4, 32'd1);
      p0 = fr_pulses;
`ifdef PULSE_CFG_TIMEOUT_EN
      cyc(DT);
      chk("tmo_force_pre", force_rst_o, 0);
      chk("tmo_err_pre", tmo_err_o, 0);
      cyc(1);
      chk("tmo_force_on", force_rst_o, 1);
      chk("tmo_err_set", tmo_err_o, 1);
      cyc(1);
      chk("tmo_force_off", force_rst_o, 0);
      cyc(2);
      chk("tmo_delay_pre", delay_o, 0);
      cyc(1);
      chk("tmo_delay", delay_o, 300);
      chk("tmo_width", width_o, 20);
      chk("tmo_cnt", cnt_o, 1);
      chk("tmo_pulses", fr_pulses - p0, 1);
      wr(3'd4, 32'd0);
      chk("tmo_err_clr", tmo_err_o, 0);
      queue = 11'd0;
`else
      cyc(DT + 20);
      chk("wait_pulses", fr_pulses - p0, 0);
      chk("wait_tmo", tmo_err_o, 0);
      chk("wait_busy", busy_o, 1);
      chk("wait_delay", delay_o, 0);
      queue = 11'd0;
      cyc(3);
      chk("wait_delay_done", delay_o, 300);
`endif

      // two back-to-back COMMITs merge into one
      do_reset();
      wr(3'd2, 32'd20);
      wr(3'd4, 32'd1);
      wr(3'd4, 32'd1);
      cyc(10);
      chk("merge_cnt", cnt_o, 1);
      chk("merge_busy", busy_o, 0);

      // shadow write during DRAIN does not disturb the in-flight commit
      do_reset();
      wr(3'd2, 32'd20);
      wr(3'd0, 32'd100);
      queue = 11'd5;
      wr(3'd4, 32'd1);
      cyc(3);
      wr(3'd0, 32'd7);
      cyc(2);
      queue = 11'd0;
      cyc(4);
      chk("iso_delay", delay_o, 100);
      chk("iso_cnt", cnt_o, 1);
      wr(3'd4, 32'd1);
      cyc(4);
      chk("iso_next_delay", delay_o, 7);

      // reset asserted mid-FLUSH
      do_reset();
      wr(3'd2, 32'd20);
      wr(3'd0, 32'd100);
      wr(3'd4, 32'd1);
      cyc(4);
      wr(3'd4, 32'd2);
      cyc(1);
      chk("mf_force_on", force_rst_o, 1);
      rst_n = 1'b0;
      #1;
      chk("mf_delay", delay_o, 0);
      chk("mf_width", width_o, 0);
      chk("mf_cnt", cnt_o, 0);
      chk("mf_force", force_rst_o, 0);
      chk("mf_busy", busy_o, 0);
      cyc(1);
      rst_n = 1'b1;
      p0 = fr_pulses;
      cyc(5);
      chk("mf_no_pulse", fr_pulses - p0, 0);
      chk("mf_busy_after", busy_o, 0);

      // vector table
      do_reset();
      for (int i = 0; i < 12; i++) begin
         p0 = fr_pulses;
         wr(tbl[i].addr, tbl[i].data);
         cyc(12);
         chk($sformatf("tbl%0d_delay", i), delay_o, tbl[i].e_delay);
         chk($sformatf("tbl%0d_width", i), width_o, tbl[i].e_width);
         chk($sformatf("tbl%0d_cnt", i), cnt_o, tbl[i].e_cnt);
         chk($sformatf("tbl%0d_cfg", i), cfg_err_o, tbl[i].e_cfg);
         chk($sformatf("tbl%0d_busy", i), busy_o, 0);
         chk($sformatf("tbl%0d_pulses", i), fr_pulses - p0, tbl[i].e_pulses);
      end

      // randomized commit transactions against the model
      do_reset();
      m_sh_d = '0; m_sh_w = '0; m_delay = '0; m_width = '0; m_cnt = '0; m_cfg = 1'b0;
      for (int it = 0; it < 40; it++) begin
         int nw, q, n, lat;
         bit done;
         nw = $urandom_range(1, 3);
         for (int k = 0; k < nw; k++) begin
            logic [2:0]  a;
            logic [31:0] d;
            a = 3'($urandom_range(0, 3));
            d = $urandom;
            if ((a == 3'd2) && ($urandom_range(0, 2) == 0)) d = 32'd0;
            if ((a == 3'd3) && ($urandom_range(0, 1) == 0)) d = 32'd0;
            case (a)
               3'd0: m_sh_d[31:0]  = d;
               3'd1: m_sh_d[47:32] = d[15:0];
               3'd2: m_sh_w[31:0]  = d;
               default: m_sh_w[47:32] = d[15:0];
            endcase
            wr(a, d);
         end
         q = $urandom_range(0, 20);
         if (q > 0) begin
            if ($urandom_range(0, 1) == 1) queue = 11'($urandom_range(1, 2047));
            else out_lvl = 1'b1;
         end
         wr(3'd4, 32'd1);
         if (m_sh_w == '0) lat = 1;
         else lat = (q + 2 > 3) ? q + 2 : 3;
         n = 0;
         done = 1'b0;
         while (!done && n < 200) begin
            cyc(1);
            n++;
            if (!busy_o) done = 1'b1;
            else if (n == q) begin
               queue = 11'd0;
               out_lvl = 1'b0;
            end
         end
         queue = 11'd0;
         out_lvl = 1'b0;
         chk($sformatf("rnd%0d_done", it), done, 1);
         chk($sformatf("rnd%0d_latency", it), n, lat);
         if (m_sh_w == '0) m_cfg = 1'b1;
         else begin
            m_delay = m_sh_d;
            m_width = m_sh_w;
            m_cnt   = m_cnt + 16'd1;
         end
         chk($sformatf("rnd%0d_delay", it), delay_o, m_delay);
         chk($sformatf("rnd%0d_width", it), width_o, m_width);
         chk($sformatf("rnd%0d_cnt", it), cnt_o, m_cnt);
         chk($sformatf("rnd%0d_cfg", it), cfg_err_o, m_cfg);
         if (m_cfg) begin
            wr(3'd4, 32'd0);
            m_cfg = 1'b0;
            chk($sformatf("rnd%0d_cfg_clr", it), cfg_err_o, m_cfg);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
